// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: bus widths, header
// field layout, channel addresses and the transmit FSM state encoding.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    // Header byte layout: {len[5:0], addr[1:0]}
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = ADDR_W;

    localparam logic [ADDR_W-1:0] CH0      = 2'd0;
    localparam logic [ADDR_W-1:0] CH1      = 2'd1;
    localparam logic [ADDR_W-1:0] CH2      = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_BAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_DONE    = 3'd5
    } tx_state_t;

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: synchronous FIFO with combinational head read and
// pointers that wrap modulo DEPTH.
module router_tx_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     level;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);
    assign full    = (level == CW'(DEPTH));

    rd_on_empty: assert property (@(posedge clk) disable iff (reset) rd_en |-> !empty);

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: collects a whole payload, then sends header,
// payload and parity to the router input port under busy back-pressure.
module router_pkt_tx #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int LEN_W  = router_pkg::LEN_W,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pay_valid,
    input  logic [DATA_W-1:0] pay_data,
    output logic              pay_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_done,
    output logic              bad_req,
    output logic [2:0]        state_dbg
);

    import router_pkg::*;

    // Handshakes: req and pay transfer on a rising edge where valid & ready;
    // ready never depends on valid. Router side transfers on edges with busy=0.

    tx_state_t         state_q, state_d;
    logic [1:0]        addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic [DATA_W-1:0] parity_q;
    logic [DATA_W-1:0] header;
    logic              bad_req_q;
    logic              req_fire;
    logic              pay_fire;
    logic              buf_rd;
    logic              buf_empty;
    logic              buf_full;
    logic [DATA_W-1:0] buf_data;

    assign header    = DATA_W'({len_q, addr_q});
    assign req_fire  = req_valid & req_ready;
    assign pay_fire  = pay_valid & pay_ready;
    assign bad_req   = bad_req_q;
    assign state_dbg = state_q;

    router_tx_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pay_fire),
        .wr_data (pay_data),
        .rd_en   (buf_rd),
        .rd_data (buf_data),
        .empty   (buf_empty),
        .full    (buf_full)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        pay_ready = 1'b0;
        pkt_valid = 1'b0;
        data_out  = '0;
        pkt_done  = 1'b0;
        buf_rd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && req_addr != ADDR_BAD) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                pay_ready = (count_q < len_q);
                if (count_q == len_q) state_d = S_HEADER;
            end
            S_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = header;
                if (!busy) state_d = (len_q == '0) ? S_PARITY : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = buf_data;
                if (!busy) begin
                    buf_rd = 1'b1;
                    if (count_q == len_q - LEN_W'(1)) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                data_out = parity_q;
                if (!busy) state_d = S_DONE;
            end
            S_DONE: begin
                pkt_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // count_q counts collected bytes, then is reused to count sent bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            parity_q  <= '0;
            bad_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bad_req_q <= req_fire && (req_addr == ADDR_BAD);
            if (req_fire && req_addr != ADDR_BAD) begin
                addr_q   <= req_addr;
                len_q    <= req_len;
                count_q  <= '0;
                parity_q <= DATA_W'({req_len, req_addr});
            end
            if (pay_fire) begin
                parity_q <= parity_q ^ pay_data;
                count_q  <= count_q + LEN_W'(1);
            end
            if (state_q == S_HEADER && !busy) count_q <= '0;
            if (buf_rd) count_q <= count_q + LEN_W'(1);
        end
    end

    wr_on_full: assert property (@(posedge clk) disable iff (reset) pay_fire |-> !buf_full);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: request/payload drivers push expected router-side
// bytes into a queue; a negedge monitor pops and compares them.
module tb_router_pkt_tx;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       pay_valid;
  logic [7:0] pay_data;
  logic       pay_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       pkt_done;
  logic       bad_req;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // Entry: {1 = sent with pkt_valid high / 0 = parity byte, byte}
  logic [8:0] exp_q[$];
  logic [7:0] pay_q[$];
  bit mid_pkt = 0;
  bit await_par = 0;
  bit await_done = 0;
  bit flush = 0;
  bit rand_busy = 0;
  bit pay_ready_seen = 0;

  router_pkt_tx dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pay_valid (pay_valid),
    .pay_data  (pay_data),
    .pay_ready (pay_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .pkt_done  (pkt_done),
    .bad_req   (bad_req),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    if (rand_busy) begin
      #1;
      busy = ($urandom_range(0, 3) == 0);
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (pay_ready) pay_ready_seen = 1;
    if (flush) begin
      exp_q.delete();
      mid_pkt = 0;
      await_par = 0;
      await_done = 0;
      flush = 0;
    end else if (!reset) begin
      if (await_done) begin
        check("pkt_done", pkt_done, 1);
        check("done_data", data_out, 0);
        await_done = 0;
      end else if (pkt_done) begin
        check("pkt_done_spurious", pkt_done, 0);
      end
      if (pkt_valid) begin
        if (exp_q.size() == 0 || exp_q[0][8] == 1'b0) begin
          check("pkt_valid_unexpected", pkt_valid, 0);
        end else begin
          check("data_byte", data_out, exp_q[0][7:0]);
          if (!busy) begin
            void'(exp_q.pop_front());
            mid_pkt = (exp_q.size() > 0) && exp_q[0][8];
            await_par = !mid_pkt && (exp_q.size() > 0);
          end
        end
      end else if (mid_pkt) begin
        check("pkt_gap", pkt_valid, 1);
        mid_pkt = 0;
      end else if (await_par) begin
        check("parity", data_out, exp_q[0][7:0]);
        if (!busy) begin
          void'(exp_q.pop_front());
          await_par = 0;
          await_done = 1;
        end
      end
    end
  end

  // driver tasks: all start and return at posedge + 1
  task automatic fill_random(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_req(input logic [1:0] a, input logic [5:0] l);
    int h;
    int par;
    int n;
    if (a != 2'd3) begin
      h = l * 4 + a;
      par = h;
      exp_q.push_back({1'b1, 8'(h)});
      foreach (pay_q[i]) begin
        par = par ^ pay_q[i];
        exp_q.push_back({1'b1, pay_q[i]});
      end
      exp_q.push_back({1'b0, 8'(par)});
    end
    req_addr = a;
    req_len = l;
    req_valid = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 500) begin
        check("req_ready_timeout", req_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    check("bad_req", bad_req, (a == 2'd3));
    check("req_ready_after", req_ready, (a == 2'd3));
    check("pkt_valid_after_req", pkt_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_payload(input int gap_max);
    int n;
    bit acc;
    while (pay_q.size() > 0) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      pay_valid = 1;
      pay_data = pay_q[0];
      n = 0;
      acc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = pay_ready;
        @(posedge clk);
        #1;
        n++;
        if (n > 500) begin
          check("pay_ready_timeout", pay_ready, 1);
          pay_q.delete();
          break;
        end
      end
      if (pay_q.size() > 0) void'(pay_q.pop_front());
      pay_valid = 0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !await_done && !await_par) break;
      n++;
      if (n > 3000) begin
        check("drain_timeout", exp_q.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pkt_valid();
    int n = 0;
    forever begin
      @(negedge clk);
      if (pkt_valid) break;
      n++;
      if (n > 500) begin
        check("pkt_valid_timeout", pkt_valid, 1);
        break;
      end
    end
  endtask

  task automatic wait_xfers(input int want);
    int got = 0;
    int n = 0;
    while (got < want) begin
      @(negedge clk);
      if (pkt_valid && !busy) got++;
      n++;
      if (n > 500) begin
        check("xfer_timeout", got, want);
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_pay_ready"}, pay_ready, 0);
    check({tag, "_pkt_valid"}, pkt_valid, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_pkt_done"}, pkt_done, 0);
    check({tag, "_bad_req"}, bad_req, 0);
    check({tag, "_state"}, state_dbg, 32'(S_IDLE));
  endtask

  initial begin
    reset = 1;
    req_valid = 0;
    req_addr = 0;
    req_len = 0;
    pay_valid = 0;
    pay_data = 0;
    busy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 0;

    // fixed three-byte packet
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_req(2'd1, 6'd3);
    drive_payload(0);
    wait_drain();

    // zero-length packet, pay_ready must stay low
    pay_ready_seen = 0;
    pay_q.delete();
    send_req(2'd2, 6'd0);
    wait_drain();
    check("len0_pay_ready_seen", pay_ready_seen, 0);

    // back-pressure at header and after second payload byte
    busy = 1;
    pay_q = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
    send_req(2'd0, 6'd4);
    drive_payload(1);
    wait_pkt_valid();
    repeat (5) @(posedge clk);
    #1;
    busy = 0;
    wait_xfers(3);
    @(posedge clk);
    #1;
    busy = 1;
    repeat (2) @(posedge clk);
    #1;
    busy = 0;
    wait_drain();

    // illegal address is dropped
    pay_q.delete();
    send_req(2'd3, 6'd5);
    @(negedge clk);
    check("bad_req_one_cycle", bad_req, 0);
    check("bad_no_pkt_valid", pkt_valid, 0);
    @(posedge clk);
    #1;

    // two maximum-length packets with payload gaps (buffer wrap)
    for (int p = 0; p < 2; p++) begin
      fill_random(63);
      send_req(6'($urandom_range(0, 2)), 6'd63);
      drive_payload(2);
      wait_drain();
    end

    // reset during payload, then a clean packet
    fill_random(10);
    send_req(2'd1, 6'd10);
    drive_payload(0);
    wait_xfers(3);
    @(posedge clk);
    #1;
    reset = 1;
    flush = 1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 0;
    fill_random(5);
    send_req(2'd0, 6'd5);
    drive_payload(1);
    wait_drain();

    // randomized packets with random busy and ignored pay_valid
    rand_busy = 1;
    for (int p = 0; p < 10; p++) begin
      logic [1:0] a;
      logic [5:0] l;
      a = 2'($urandom_range(0, 3));
      l = (a == 2'd3) ? 6'd0 : 6'($urandom_range(0, 20));
      if (a == 2'd3) pay_q.delete();
      else fill_random(int'(l));
      send_req(a, l);
      if (a != 2'd3) begin
        drive_payload(3);
        pay_valid = 1;
        pay_data = 8'($urandom_range(0, 255));
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        pay_valid = 0;
        wait_drain();
      end
    end
    rand_busy = 0;
    @(posedge clk);
    #1;
    busy = 0;
    repeat (3) @(posedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
